mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 74 +++++++
 rtl/mem_stage.sv | 113 +++++++++++
 tb/tb_mem_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bundle types for the memory stage and its port interface.
// The stage takes the master view; execute, writeback and memory take the slave view.
package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic        reg_wen;
    logic [1:0]  reg_wb_sel;
    logic [2:0]  mem_op;
    logic        mem_wen;
    logic        mem_ren;
    logic [4:0]  reg_waddr;
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic        branch_taken;
  } exe_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_4;
    logic        reg_wen;
    logic [1:0]  reg_wb_sel;
    logic [4:0]  reg_waddr;
    logic [31:0] alu_out;
    logic [31:0] load_data;
  } mem_wb_t;

  localparam int EXE_MEM_BUS_WIDTH = $bits(exe_mem_t);
  localparam int MEM_WB_BUS_WIDTH  = $bits(mem_wb_t);
endpackage

interface mem_stage_if;
  import mem_stage_pkg::*;
  logic [EXE_MEM_BUS_WIDTH-1:0] exe_mem_bus;
  logic                         s_valid;
  logic                         s_ready;
  logic                         m_valid;
  logic                         m_ready;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [31:0]                  mem_req_addr;
  logic [31:0]                  mem_req_wdata;
  logic                         mem_req_wen;
  logic [3:0]                   mem_req_wmask;
  logic                         mem_resp_valid;
  logic [31:0]                  mem_resp_rdata;
  logic [MEM_WB_BUS_WIDTH-1:0]  mem_wb_bus;
  logic [31:0]                  exe_mem_reg_alu_out;
  logic [4:0]                   exe_mem_reg_waddr;
  logic                         exe_mem_reg_wen;
  logic                         exe_mem_reg_mem_ren;

  modport master (
    input  exe_mem_bus, s_valid, m_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output s_ready, m_valid, mem_wb_bus,
    output mem_req_valid, mem_req_addr, mem_req_wdata,
    output mem_req_wen, mem_req_wmask,
    output exe_mem_reg_alu_out, exe_mem_reg_waddr,
    output exe_mem_reg_wen, exe_mem_reg_mem_ren
  );

  modport slave (
    output exe_mem_bus, s_valid, m_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  s_ready, m_valid, mem_wb_bus,
    input  mem_req_valid, mem_req_addr, mem_req_wdata,
    input  mem_req_wen, mem_req_wmask,
    input  exe_mem_reg_alu_out, exe_mem_reg_waddr,
    input  exe_mem_reg_wen, exe_mem_reg_mem_ren
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: one outstanding data-memory access,
// byte/half/word load extraction and store lane steering.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master io
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  pipe_valid_q;
  exe_mem_t              ent_q, ent_in;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  in_mem, is_mem;
  logic                  ready_go, s_ready, capture;
  logic                  is_b, is_h, sx;
  logic [1:0]            a;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [31:0]           load_data, wdata;
  logic [3:0]            wmask;
  mem_wb_t               wb;
  logic                  unused_bt;

  assign ent_in   = exe_mem_t'(io.exe_mem_bus);
  assign in_mem   = ent_in.mem_ren | ent_in.mem_wen;
  assign is_mem   = ent_q.mem_ren | ent_q.mem_wen;
  assign ready_go = ~is_mem | (state_q == DONE);
  assign s_ready  = ~pipe_valid_q | (io.m_ready & ready_go);
  assign capture  = io.s_valid & s_ready;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (capture && in_mem) state_d = REQ;
      REQ:  if (io.mem_req_ready) state_d = WAIT;
      WAIT: if (io.mem_resp_valid) begin
        state_d = DONE;
        rdata_d = io.mem_resp_rdata;
      end
      DONE: if (io.m_ready) begin
        state_d = (capture && in_mem) ? REQ : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pipe_valid_q <= 1'b0;
      ent_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (s_ready) pipe_valid_q <= io.s_valid;
      if (capture) ent_q <= ent_in;
    end
  end

  assign a      = ent_q.alu_out[1:0];
  assign is_b   = ent_q.mem_op[1:0] == 2'b00;
  assign is_h   = ent_q.mem_op[1:0] == 2'b01;
  assign sx     = ~ent_q.mem_op[2];
  assign byte_v = rdata_q[{a, 3'b000} +: 8];
  assign half_v = a[1] ? rdata_q[31:16] : rdata_q[15:0];

  // Halfwords steer on alu_out[1] only; misalignment is not trapped.
  always_comb begin
    load_data = rdata_q[31:0];
    wmask     = 4'b1111;
    wdata     = ent_q.rs2;
    unique case (1'b1)
      is_b: begin
        load_data = {{24{sx & byte_v[7]}}, byte_v};
        wmask     = 4'b0001 << a;
        wdata     = {4{ent_q.rs2[7:0]}};
      end
      is_h: begin
        load_data = {{16{sx & half_v[15]}}, half_v};
        wmask     = a[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{ent_q.rs2[15:0]}};
      end
      default: ;
    endcase
    if (!ent_q.mem_ren) load_data = '0;
    if (!ent_q.mem_wen) wmask = '0;
  end

  assign wb = {ent_q.pc, ent_q.instr, ent_q.pc_4,
               ent_q.reg_wen, ent_q.reg_wb_sel,
               ent_q.reg_waddr, ent_q.alu_out, load_data};
  assign unused_bt = ent_q.branch_taken;

  assign io.s_ready       = s_ready;
  assign io.m_valid       = pipe_valid_q & ready_go;
  assign io.mem_wb_bus    = wb;
  assign io.mem_req_valid = pipe_valid_q & (state_q == REQ);
  assign io.mem_req_addr  = {ent_q.alu_out[31:2], 2'b00};
  assign io.mem_req_wdata = wdata;
  assign io.mem_req_wen   = ent_q.mem_wen;
  assign io.mem_req_wmask = wmask;

  assign io.exe_mem_reg_alu_out = pipe_valid_q ? ent_q.alu_out : '0;
  assign io.exe_mem_reg_waddr   = pipe_valid_q ? ent_q.reg_waddr : '0;
  assign io.exe_mem_reg_wen     = pipe_valid_q & ent_q.reg_wen;
  assign io.exe_mem_reg_mem_ren = pipe_valid_q & ent_q.mem_ren;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if io ();
  mem_stage #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .io(io));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exe_mem_t mk(input int kind, input logic [2:0] op,
                                  input logic [31:0] alu,
                                  input logic [31:0] rs2);
    exe_mem_t e;
    logic [31:0] r;
    r = $urandom;
    e.pc = $urandom;
    e.instr = $urandom;
    e.pc_4 = e.pc + 32'd4;
    e.reg_wen = (kind != 2);
    e.reg_wb_sel = r[1:0];
    e.mem_op = op;
    e.mem_wen = (kind == 2);
    e.mem_ren = (kind == 1);
    e.reg_waddr = r[8:4];
    e.alu_out = alu;
    e.rs2 = rs2;
    e.branch_taken = r[12];
    return e;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w,
                                           input logic [2:0] op,
                                           input logic [1:0] a);
    int unsigned v;
    case (op[1:0])
      2'b00: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (!op[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      2'b01: begin
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (!op[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_mask(input logic [2:0] op,
                                           input logic [1:0] a,
                                           input logic wen);
    if (!wen) return 0;
    case (op[1:0])
      2'b00:   return 32'd1 << a;
      2'b01:   return 32'd3 << (2 * (a / 2));
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op,
                                            input logic [31:0] rs2);
    case (op[1:0])
      2'b00:   return (rs2 & 32'hFF) * 32'h0101_0101;
      2'b01:   return (rs2 & 32'hFFFF) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  task automatic chk_wb(input exe_mem_t e, input logic [31:0] ld);
    mem_wb_t x;
    x = {e.pc, e.instr, e.pc_4, e.reg_wen, e.reg_wb_sel,
         e.reg_waddr, e.alu_out, ld};
    checks++;
    if (io.mem_wb_bus !== x) begin
      errors++;
      $display("FAIL wb_bus act=%h exp=%h", io.mem_wb_bus, x);
    end
  endtask

  task automatic mem_access(input exe_mem_t e, input logic [31:0] rd,
                            input int lag);
    io.exe_mem_bus = e;
    io.s_valid = 1'b1;
    io.m_ready = 1'b1;
    io.mem_req_ready = 1'b0;
    tick;
    io.s_valid = 1'b0;
    for (int i = 0; i <= lag; i++) begin
      chk("req_valid", io.mem_req_valid, 1);
      chk("req_addr", io.mem_req_addr, {e.alu_out[31:2], 2'b00});
      chk("s_ready_busy", io.s_ready, 0);
      chk("m_valid_busy", io.m_valid, 0);
      if (i == lag) io.mem_req_ready = 1'b1;
      tick;
    end
    io.mem_req_ready = 1'b0;
    chk("wait_req_valid", io.mem_req_valid, 0);
    tick;
    chk("wait_m_valid", io.m_valid, 0);
    io.mem_resp_valid = 1'b1;
    io.mem_resp_rdata = rd;
    tick;
    io.mem_resp_valid = 1'b0;
    io.mem_resp_rdata = $urandom;
  endtask

  initial begin
    exe_mem_t e, e2, held_e, cur;
    mem_wb_t g;
    logic [31:0] mem [16];
    logic [31:0] held_ld, resp_word, r, wd, mk_m;
    bit held, done, req_pend, waiting;
    int resp_cnt, kind;
    logic [2:0] op;

    io.s_valid = 1'b0;
    io.m_ready = 1'b0;
    io.exe_mem_bus = '0;
    io.mem_req_ready = 1'b0;
    io.mem_resp_valid = 1'b0;
    io.mem_resp_rdata = '0;

    chk("model_lb", exp_load(32'h80FF_0000, 3'b000, 2'd3), 32'hFFFF_FF80);
    chk("model_lhu", exp_load(32'h8001_7FFF, 3'b101, 2'd2), 32'h0000_8001);
    chk("model_sb", exp_mask(3'b000, 2'd2, 1'b1), 32'h4);

    rst = 1'b1;
    tick;
    tick;
    chk("rst_s_ready", io.s_ready, 1);
    chk("rst_m_valid", io.m_valid, 0);
    chk("rst_req_valid", io.mem_req_valid, 0);
    chk("rst_tap_alu", io.exe_mem_reg_alu_out, 0);
    chk("rst_tap_ctl", {io.exe_mem_reg_waddr, io.exe_mem_reg_wen,
                        io.exe_mem_reg_mem_ren}, 0);
    rst = 1'b0;

    e = mk(0, 3'b010, 32'h1234, 32'h0);
    io.exe_mem_bus = e;
    io.s_valid = 1'b1;
    io.m_ready = 1'b1;
    tick;
    io.s_valid = 1'b0;
    g = io.mem_wb_bus;
    chk("alu_m_valid", io.m_valid, 1);
    chk("alu_req_valid", io.mem_req_valid, 0);
    chk("alu_wb_alu", g.alu_out, 32'h1234);
    chk("alu_wb_load", g.load_data, 0);
    chk("alu_tap", io.exe_mem_reg_alu_out, 32'h1234);
    tick;
    chk("alu_drained", io.m_valid, 0);
    chk("alu_tap_off", io.exe_mem_reg_alu_out, 0);

    e = mk(1, 3'b000, 32'h8000_0003, 32'h0);
    mem_access(e, 32'h80FF_0000, 0);
    g = io.mem_wb_bus;
    chk("lb_m_valid", io.m_valid, 1);
    chk("lb_data", g.load_data, 32'hFFFF_FF80);
    tick;
    e = mk(1, 3'b100, 32'h8000_0003, 32'h0);
    mem_access(e, 32'h80FF_0000, 0);
    g = io.mem_wb_bus;
    chk("lbu_data", g.load_data, 32'h0000_0080);
    tick;

    e = mk(2, 3'b001, 32'h8000_0002, 32'hABCD_1234);
    mem_access(e, 32'h0, 3);
    g = io.mem_wb_bus;
    chk("sh_wmask", {28'b0, io.mem_req_wmask}, 32'hC);
    chk("sh_wdata", io.mem_req_wdata, 32'h1234_1234);
    chk("sh_wen", io.mem_req_wen, 1);
    chk("sh_m_valid", io.m_valid, 1);
    tick;

    e = mk(1, 3'b010, 32'h8000_0010, 32'h0);
    mem_access(e, 32'hCAFE_F00D, 0);
    io.m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      g = io.mem_wb_bus;
      chk("hold_m_valid", io.m_valid, 1);
      chk("hold_data", g.load_data, 32'hCAFE_F00D);
      chk("hold_s_ready", io.s_ready, 0);
      tick;
    end
    e2 = mk(2, 3'b010, 32'h8000_0014, 32'h5555_AAAA);
    io.exe_mem_bus = e2;
    io.s_valid = 1'b1;
    io.m_ready = 1'b1;
    #1;
    g = io.mem_wb_bus;
    chk("b2b_s_ready", io.s_ready, 1);
    chk("b2b_data", g.load_data, 32'hCAFE_F00D);
    tick;
    io.s_valid = 1'b0;
    chk("b2b_req", io.mem_req_valid, 1);
    chk("b2b_m_valid", io.m_valid, 0);
    chk("b2b_wdata", io.mem_req_wdata, 32'h5555_AAAA);
    chk("b2b_wmask", {28'b0, io.mem_req_wmask}, 32'hF);
    io.mem_req_ready = 1'b1;
    tick;
    io.mem_req_ready = 1'b0;
    io.mem_resp_valid = 1'b1;
    tick;
    io.mem_resp_valid = 1'b0;
    chk("b2b_st_done", io.m_valid, 1);
    tick;

    e = mk(1, 3'b010, 32'h8000_0020, 32'h0);
    io.exe_mem_bus = e;
    io.s_valid = 1'b1;
    tick;
    io.s_valid = 1'b0;
    io.mem_req_ready = 1'b1;
    tick;
    io.mem_req_ready = 1'b0;
    chk("rw_in_wait", io.mem_req_valid, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    io.mem_resp_valid = 1'b1;
    io.mem_resp_rdata = 32'h1111_2222;
    tick;
    io.mem_resp_valid = 1'b0;
    chk("rw_m_valid", io.m_valid, 0);
    chk("rw_s_ready", io.s_ready, 1);
    chk("rw_req", io.mem_req_valid, 0);
    chk("rw_tap", {io.exe_mem_reg_alu_out[26:0], io.exe_mem_reg_waddr}, 0);
    tick;
    chk("rw_m_valid2", io.m_valid, 0);
    chk("rw_req2", io.mem_req_valid, 0);

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    held = 0;
    done = 0;
    req_pend = 0;
    waiting = 0;
    resp_cnt = 0;
    held_ld = 0;
    resp_word = 0;
    held_e = '0;
    cur = '0;
    io.s_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit exp_mv, exp_sr, f_in, f_out, f_req, f_resp;
      @(negedge clk);
      exp_mv = held && done;
      exp_sr = !held || (exp_mv && io.m_ready);
      chk("s_ready", io.s_ready, exp_sr);
      chk("m_valid", io.m_valid, exp_mv);
      chk("req_valid", io.mem_req_valid, held && req_pend);
      chk("tap_alu", io.exe_mem_reg_alu_out, held ? held_e.alu_out : 0);
      chk("tap_ctl", {io.exe_mem_reg_waddr, io.exe_mem_reg_wen,
                      io.exe_mem_reg_mem_ren},
          held ? {held_e.reg_waddr, held_e.reg_wen, held_e.mem_ren} : 0);
      if (held && req_pend) begin
        chk("req_addr", io.mem_req_addr, {held_e.alu_out[31:2], 2'b00});
        chk("req_wen", io.mem_req_wen, held_e.mem_wen);
        chk("req_wmask", {28'b0, io.mem_req_wmask},
            exp_mask(held_e.mem_op, held_e.alu_out[1:0], held_e.mem_wen));
        if (held_e.mem_wen)
          chk("req_wdata", io.mem_req_wdata,
              exp_wdata(held_e.mem_op, held_e.rs2));
      end
      if (exp_mv) chk_wb(held_e, held_ld);
      f_out = exp_mv && io.m_ready;
      f_in = io.s_valid && exp_sr;
      f_req = held && req_pend && io.mem_req_ready;
      f_resp = waiting && io.mem_resp_valid;
      @(posedge clk);
      #1;
      if (f_req) begin
        req_pend = 0;
        waiting = 1;
        resp_cnt = $urandom_range(0, 2);
        if (held_e.mem_wen) begin
          mk_m = exp_mask(held_e.mem_op, held_e.alu_out[1:0], 1'b1);
          wd = exp_wdata(held_e.mem_op, held_e.rs2);
          for (int b = 0; b < 4; b++)
            if (mk_m[b]) mem[held_e.alu_out[5:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
      if (f_resp) begin
        waiting = 0;
        done = 1;
        held_ld = held_e.mem_ren ?
          exp_load(resp_word, held_e.mem_op, held_e.alu_out[1:0]) : 0;
      end
      if (f_out) held = 0;
      if (f_in) begin
        held = 1;
        held_e = cur;
        done = !(cur.mem_ren || cur.mem_wen);
        req_pend = !done;
        held_ld = 0;
      end
      if (f_in || !io.s_valid) begin
        r = $urandom;
        kind = r % 3;
        op = 3'(($urandom) % 3);
        if (kind == 1 && r[8] && op != 3'b010) op[2] = 1'b1;
        cur = mk(kind, op,
                 kind == 0 ? $urandom : (32'h8000_0000 | (r & 32'h3C) |
                                         ($urandom & 32'h3)),
                 $urandom);
        io.exe_mem_bus = cur;
        io.s_valid = r[20] | r[21];
      end
      r = $urandom;
      io.m_ready = r[0] | r[1];
      io.mem_req_ready = r[2];
      if (waiting) begin
        if (resp_cnt == 0) begin
          resp_word = mem[held_e.alu_out[5:2]];
          io.mem_resp_valid = 1'b1;
          io.mem_resp_rdata = resp_word;
        end else begin
          resp_cnt--;
          io.mem_resp_valid = 1'b0;
          io.mem_resp_rdata = $urandom;
        end
      end else begin
        io.mem_resp_valid = (r[7:5] == 3'b000);
        io.mem_resp_rdata = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
